load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the ALU. Takes the ALU result as the effective address, together with rs2 store data and funct3.
- Runs one valid/ready transaction on the word-wide data-memory port.
- Returns sign/zero-extended load data, or completes a store with byte strobes.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ready; used only when LSU_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request from execute stage
- req_ready  output  1  unit idle and able to accept a request
- is_load  input  1  request is a load
- is_store  input  1  request is a store
- funct3  input  3  RISC-V width/sign encoding
- addr  input  32  effective address (ALU result)
- store_data  input  32  rs2 value
- done  output  1  one-cycle completion pulse
- load_data  output  32  aligned, extended load result
- misaligned  output  1  valid with done: access rejected
- bus_error  output  1  valid with done: timeout abort
- mem_valid  output  1  memory request
- mem_ready  input  1  memory accepts/completes the request
- mem_addr  output  32  word address, {addr[31:2],2'b00}
- mem_wdata  output  32  replicated store data
- mem_wstrb  output  4  byte enables; 0000 for loads
- mem_rdata  input  32  read data, valid in the mem_valid&&mem_ready cycle

Behaviour:
- Reset:
  - One clock (clk); reset is asynchronous, active-high.
  - Asserting reset forces state IDLE.
  - Reset values: mem_valid=0, done=0, misaligned=0, bus_error=0, load_data=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - Reset mid-transaction drops mem_valid immediately (asynchronous) and abandons the access.
- States: IDLE, MEM, DONE.
- req_ready=1 only in IDLE.
- IDLE:
  - req_valid is accepted at the clock edge.
  - All request fields are captured in that edge.
- Illegal request; any one of these causes it:
  - is_load and is_store both 0 or both 1.
  - Load funct3 in {011,110,111}.
  - Store funct3 not in {000,001,010}.
- Misaligned request:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=00.
- Illegal or misaligned request: go to DONE with misaligned=1. No mem_valid is ever raised.
- Legal request: go to MEM.
  - mem_valid=1 from the next cycle and held with stable addr/wdata/wstrb until the mem_valid&&mem_ready edge.
  - At that edge: mem_valid→0, load data is captured and aligned, and the state goes to DONE.
- DONE:
  - done=1 for exactly one cycle, then back to IDLE.
  - misaligned and bus_error are meaningful only while done=1 and are cleared on leaving DONE.
- Latency:
  - Accept at edge N; mem_valid is high in cycle N+1.
  - If mem_ready=1 in N+1, done is high in cycle N+2.
  - Each wait cycle adds 1.
  - Error path: done in cycle N+1.
- Back-to-back: a new request can be accepted in the cycle after done.
- Stores:
  - SB: wstrb=0001<<addr[1:0], wdata={4{store_data[7:0]}}.
  - SH: wstrb=0011<<addr[1:0], wdata={2{store_data[15:0]}}.
  - SW: wstrb=1111, wdata=store_data.
- Loads: the byte/half is selected by addr[1:0] from mem_rdata.
  - LB, LH: sign-extended.
  - LBU, LHU: zero-extended.
  - LW: passthrough.
- load_data:
  - Holds its value until the next load completes.
  - Stores and errors leave it unchanged.
- req_valid is ignored outside IDLE. The upstream stage must hold it until the cycle after acceptance, then it may change freely.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to MEM and increments each MEM cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES with no handshake, mem_valid drops, state goes to DONE, and done pulses with bus_error=1. load_data is unchanged.
  - A handshake in the same cycle as the limit wins: normal completion, bus_error=0.
- Not defined:
  - No counter; MEM waits indefinitely.
  - bus_error tied to 0.

Test Plan:
- LW addr=0x100, mem_ready=1 immediately, mem_rdata=0xDEADBEEF:
  - mem_addr=0x100, wstrb=0000.
  - done 2 cycles after accept, load_data=0xDEADBEEF.
- LB addr=0x103, rdata=0x80112233 → load_data=0xFFFFFF80.
- LBU same → 0x00000080.
- LHU addr=0x102 → 0x00008011.
- SB addr=0x201, store_data=0x000000AB → mem_addr=0x200, wstrb=0010, wdata=0xABABABAB.
- SH addr=0x202, store_data=0x1234 → wstrb=1100, wdata=0x12341234.
- LW addr=0x102 → misaligned=1 with done 1 cycle after accept; mem_valid never 1.
- funct3=011 load → same response as LW addr=0x102.
- mem_ready held 0 for 5 cycles then 1 → mem_valid and mem_addr stable 6 cycles; done once.
- Reset asserted while in MEM → mem_valid=0 immediately, req_ready=1 after release, no done pulse.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready=0 forever → done with bus_error=1 and mem_valid low afterwards.
- Without LSU_TIMEOUT_EN, same stimulus → mem_valid stays high indefinitely.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU running one valid/ready data-memory access per request.
// Optional LSU_TIMEOUT_EN: abort with bus_error after TIMEOUT_CYCLES stalled MEM cycles.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  state_t      state, state_nxt;
  logic        bad_op, bad_align, reject;
  logic        hs, timeout;
  logic        err_q, ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  strb;
  logic [31:0] wdata, shifted, ext;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  assign bad_op = (is_load == is_store) ||
                  (is_load ? (funct3 inside {3'b011, 3'b110, 3'b111})
                           : !(funct3 inside {3'b000, 3'b001, 3'b010}));
  assign bad_align = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign reject = bad_op || bad_align;

  assign hs         = (state == MEM) && mem_ready;
  assign req_ready  = (state == IDLE);
  assign mem_valid  = (state == MEM);
  assign done       = (state == DONE);
  assign misaligned = done && err_q;

  always_comb begin
    strb  = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        strb  = 4'b0001 << addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << addr[1:0];
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // lane select; word accesses are aligned so shifted == mem_rdata
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt;
  logic        berr_q;

  assign timeout = (state == MEM) && !mem_ready &&
                   ({16'd0, cnt} + 32'd1 >= TIMEOUT_CYCLES);
  assign bus_error = done && berr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt    <= (state == MEM && !mem_ready) ? cnt + 16'd1 : 16'd0;
      berr_q <= (state == MEM) ? timeout : 1'b0;
    end
  end
`else
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = reject ? DONE : MEM;
      MEM:  if (hs || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q     <= 1'b0;
      ld_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      load_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          err_q <= reject;
          ld_q  <= is_load;
          f3_q  <= funct3;
          off_q <= addr[1:0];
          if (!reject) begin
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata;
            mem_wstrb <= is_load ? 4'b0000 : strb;
          end
        end
        MEM:  if (hs && ld_q) load_data <= ext;
        DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + randomized bench with a behavioural LSU model.
// Define LSU_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data, mem_addr, mem_wdata, mem_rdata;
  logic        done, misaligned, bus_error, mem_valid, mem_ready;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  logic        exp_en = 1'b0;
  logic        e_ready, e_mvalid, e_done, e_mis, e_berr;
  logic [31:0] e_addr, e_wdata, model_ld;
  logic [3:0]  e_strb;

  int          mv_cnt, done_cnt, obs_lat;
  logic        obs_mis, obs_berr;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_strb;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_error(bus_error),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model
  function automatic logic bad_f(input logic ld, st,
                                 input logic [2:0] f3,
                                 input logic [31:0] a);
    int sz;
    logic il;
    il = (ld == st);
    if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) il = 1'b1;
    if (st && f3 > 3'd2) il = 1'b1;
    sz = 1 << f3[1:0];
    if (!il && (int'(a[2:0]) % sz) != 0) il = 1'b1;
    return il;
  endfunction

  function automatic logic [3:0] strb_f(input logic [2:0] f3,
                                        input logic [1:0] off);
    logic [3:0] s;
    int sz;
    sz = 1 << f3[1:0];
    for (int k = 0; k < 4; k++)
      s[k] = (k >= int'(off)) && (k < int'(off) + sz);
    return s;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [2:0] f3,
                                          input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = 1 << f3[1:0];
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = sd[8*(k % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] load_f(input logic [2:0] f3,
                                         input logic [1:0] off,
                                         input logic [31:0] rd);
    longint v;
    int bits;
    bits = 8 * (1 << f3[1:0]);
    v = (longint'(rd) >> (8 * int'(off))) & ((64'd1 << bits) - 1);
    if (!f3[2] && bits < 32 && ((v >> (bits - 1)) & 1) == 1)
      v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (exp_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, e_mvalid});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("load_data", load_data, model_ld);
      if (e_mvalid) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_strb});
        if (e_strb != 4'd0) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_done) begin
        chk("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
        chk("bus_error", {31'd0, bus_error}, {31'd0, e_berr});
      end
    end
  end

  task automatic set_idle();
    e_ready = 1'b1; e_mvalid = 1'b0; e_done = 1'b0;
    e_mis = 1'b0; e_berr = 1'b0;
  endtask

  task automatic scramble();
    req_valid  = 1'($urandom);
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
  endtask

  task automatic sample(input int c);
    if (mem_valid) begin
      mv_cnt++;
      obs_addr = mem_addr; obs_strb = mem_wstrb; obs_wdata = mem_wdata;
    end
    if (done) begin
      done_cnt++;
      obs_lat = c; obs_mis = misaligned; obs_berr = bus_error;
    end
  endtask

  // called one time unit after a rising edge with the DUT idle
  task automatic txn(input logic ld, st, input logic [2:0] f3,
                     input logic [31:0] a, sd, rd, input int w);
    int c;
    mv_cnt = 0; done_cnt = 0; obs_lat = -1;
    obs_mis = 1'b0; obs_berr = 1'b0;
    is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; req_valid = 1'b1; mem_ready = 1'b0;
    set_idle();
    @(posedge clk); #1;
    scramble();
    c = 1;
    if (bad_f(ld, st, f3, a)) begin
      e_ready = 1'b0; e_mvalid = 1'b0; e_done = 1'b1;
      e_mis = 1'b1; e_berr = 1'b0;
      sample(c);
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i < 100000; i++) begin
        mem_ready = (i == w);
        mem_rdata = (i == w) ? rd : $urandom;
        e_ready = 1'b0; e_mvalid = 1'b1; e_done = 1'b0;
        e_addr  = {a[31:2], 2'b00};
        e_strb  = ld ? 4'd0 : strb_f(f3, a[1:0]);
        e_wdata = wdata_f(f3, sd);
        sample(c);
        @(posedge clk); #1;
        c++;
        scramble();
        if (i == w) begin
          if (ld) model_ld = load_f(f3, a[1:0], rd);
          e_berr = 1'b0;
          break;
        end
`ifdef LSU_TIMEOUT_EN
        if (i + 1 >= TO) begin
          e_berr = 1'b1;
          break;
        end
`endif
      end
      mem_ready = 1'b0;
      e_ready = 1'b0; e_mvalid = 1'b0; e_done = 1'b1; e_mis = 1'b0;
      sample(c);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_ready = 1'b0;
    set_idle();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = '0; addr = '0; store_data = '0; mem_ready = 1'b0;
    mem_rdata = '0; model_ld = '0;
    set_idle();
    e_addr = '0; e_strb = '0; e_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_en = 1'b1;

    txn(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
    chk("lw_addr", obs_addr, 32'h100);
    chk("lw_wstrb", {28'd0, obs_strb}, 32'd0);
    chk("lw_latency", obs_lat, 2);
    chk("lw_data", load_data, 32'hDEADBEEF);

    txn(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0);
    chk("lb_data", load_data, 32'hFFFFFF80);
    txn(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 1);
    chk("lbu_data", load_data, 32'h00000080);
    txn(1, 0, 3'b101, 32'h102, 0, 32'h80112233, 0);
    chk("lhu_data", load_data, 32'h00008011);

    txn(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 0);
    chk("sb_addr", obs_addr, 32'h200);
    chk("sb_wstrb", {28'd0, obs_strb}, 32'h2);
    chk("sb_wdata", obs_wdata, 32'hABABABAB);
    chk("sb_keeps_ld", load_data, 32'h00008011);
    txn(0, 1, 3'b001, 32'h202, 32'h00001234, 0, 2);
    chk("sh_wstrb", {28'd0, obs_strb}, 32'hC);
    chk("sh_wdata", obs_wdata, 32'h12341234);

    txn(1, 0, 3'b010, 32'h102, 0, 0, 0);
    chk("mis_latency", obs_lat, 1);
    chk("mis_flag", {31'd0, obs_mis}, 32'd1);
    chk("mis_no_mem", mv_cnt, 0);
    txn(1, 0, 3'b011, 32'h100, 0, 0, 0);
    chk("ill_latency", obs_lat, 1);
    chk("ill_flag", {31'd0, obs_mis}, 32'd1);
    chk("ill_no_mem", mv_cnt, 0);

    txn(1, 0, 3'b010, 32'h180, 0, 32'h0BADF00D, 5);
    chk("wait_mv_cycles", mv_cnt, 6);
    chk("wait_done_cnt", done_cnt, 1);
    chk("wait_latency", obs_lat, 7);

`ifdef LSU_TIMEOUT_EN
    txn(1, 0, 3'b010, 32'h400, 0, 0, 1000);
    chk("to_bus_error", {31'd0, obs_berr}, 32'd1);
    chk("to_mv_cycles", mv_cnt, TO);
    chk("to_done_cnt", done_cnt, 1);
`else
    txn(1, 0, 3'b010, 32'h400, 0, 32'h11223344, 40);
    chk("nto_mv_cycles", mv_cnt, 41);
    chk("nto_bus_error", {31'd0, obs_berr}, 32'd0);
`endif

    // reset while the memory access is outstanding
    exp_en = 1'b0;
    is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    addr = 32'h300; req_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmem_valid_pre", {31'd0, mem_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rmem_valid_drop", {31'd0, mem_valid}, 32'd0);
    chk("rmem_no_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_ld = '0;
    chk("rmem_req_ready", {31'd0, req_ready}, 32'd1);
    set_idle();
    exp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      int r;
      logic ld, st;
      logic [31:0] a;
      r = $urandom_range(0, 19);
      ld = (r < 9) || (r == 19);
      st = (r >= 9 && r < 17) || (r == 19);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      txn(ld, st, 3'($urandom), a, $urandom, $urandom,
          $urandom_range(0, 5));
      chk("rnd_done_once", done_cnt, 1);
    end

    exp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
